alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_mul_seq.sv | 56 +++++
 rtl/alu_mc.sv | 153 +++++++++++++++
 tb/tb_alu_mc.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, flag bit positions and control state for alu_mc.
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_XOR = 5'b00100;
    localparam logic [4:0] OP_NOT = 5'b00101;
    localparam logic [4:0] OP_SLL = 5'b01000;
    localparam logic [4:0] OP_SRL = 5'b01001;
    localparam logic [4:0] OP_SRA = 5'b01010;
    localparam logic [4:0] OP_ROL = 5'b01011;
    localparam logic [4:0] OP_ROR = 5'b01100;
    localparam logic [4:0] OP_SLT = 5'b01101;
    localparam logic [4:0] OP_MUL = 5'b10000;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per enabled cycle,
// result held with done=1 until the parent takes it.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic             take,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;

    // The counter saturates at LAST, so a blocked result simply waits here.
    assign done = busy && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else if (enable) begin
            if (start) begin
                busy    <= 1'b1;
                count   <= '0;
                mcand   <= a;
                mplier  <= b;
                product <= '0;
            end else if (take) begin
                busy  <= 1'b0;
                count <= '0;
            end else if (busy && !done) begin
                if (mplier[0]) begin
                    product <= product + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus a sequential
// multiplier, all funnelled into one registered valid/ready output stage.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int M = WIDTH - 1;

    state_t state, state_next;

    logic             free, accept, is_mul, start, take;
    logic             mul_busy, mul_done;
    logic [WIDTH-1:0] prod, res, rol_w, ror_w;
    logic [3:0]       res_flags;
    logic             res_err, c, v;
    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   sum, dif, sll_w, srl_w, sra_w;

    assign free     = !out_valid || out_ready;
    assign in_ready = enable && (state == IDLE) && free;
    assign accept   = in_valid && in_ready;
    assign is_mul   = (opcode == OP_MUL);
    assign start    = accept && is_mul;
    assign take     = enable && (state == MUL) && mul_busy && mul_done && free;

    assign amt   = b[SHW-1:0];
    assign sum   = {1'b0, a} + {1'b0, b};
    assign dif   = {1'b0, a} - {1'b0, b};
    // Extra bit beside the operand catches the last bit shifted out.
    assign sll_w = {1'b0, a} << amt;
    assign srl_w = {a, 1'b0} >> amt;
    assign sra_w = $signed({a, 1'b0}) >>> amt;
    assign rol_w = WIDTH'(({a, a} << amt) >> WIDTH);
    assign ror_w = WIDTH'({a, a} >> amt);

    always_comb begin
        res     = '0;
        c       = 1'b0;
        v       = 1'b0;
        res_err = 1'b0;
        unique case (opcode)
            OP_ADD: begin
                res = sum[M:0];
                c   = sum[WIDTH];
                v   = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            OP_SUB: begin
                res = dif[M:0];
                c   = !dif[WIDTH];
                v   = (a[M] != b[M]) && (dif[M] != a[M]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_SLL: begin
                res = sll_w[M:0];
                c   = sll_w[WIDTH];
            end
            OP_SRL: begin
                res = srl_w[WIDTH:1];
                c   = srl_w[0];
            end
            OP_SRA: begin
                res = sra_w[WIDTH:1];
                c   = sra_w[0];
            end
            OP_ROL: res = rol_w;
            OP_ROR: res = ror_w;
            OP_SLT: res = {{M{1'b0}}, $signed(a) < $signed(b)};
            OP_MUL: res = '0;
            default: res_err = 1'b1;
        endcase
        res_flags = '0;
        if (!res_err) begin
            res_flags[FLAG_N] = res[M];
            res_flags[FLAG_Z] = (res == '0);
            res_flags[FLAG_C] = c;
            res_flags[FLAG_V] = v;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = MUL;
            MUL:  if (take)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            flags     <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else if (enable) begin
            if (accept && !is_mul) begin
                out       <= res;
                flags     <= res_flags;
                err       <= res_err;
                out_valid <= 1'b1;
            end else if (take) begin
                out       <= prod;
                flags     <= {prod[M], prod == '0, 2'b00};
                err       <= 1'b0;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .start   (start),
        .take    (take),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (prod)
    );

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 32;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    typedef struct packed {
        logic [W-1:0] out;
        logic [3:0]   flags;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [4:0]   opcode = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, err;
    logic [W-1:0] out;
    logic [3:0]   flags;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rnd_ready = 1'b0;

    logic [4:0] ops [13] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
                             OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR, OP_SLT,
                             OP_MUL};

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags),
        .err       (err)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t         e;
        logic [63:0]  w;
        logic [W-1:0] t;
        longint       sx, sy, sr;
        int           n;
        logic         c, v;
        e  = '0;
        c  = 1'b0;
        v  = 1'b0;
        n  = int'(y[4:0]);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            OP_ADD: begin
                w = {32'b0, x} + {32'b0, y};
                e.out = w[31:0];
                c = w[32];
                sr = sx + sy;
                v = (sr > MAXS) || (sr < MINS);
            end
            OP_SUB: begin
                e.out = x - y;
                c = (x >= y);
                sr = sx - sy;
                v = (sr > MAXS) || (sr < MINS);
            end
            OP_AND: e.out = x & y;
            OP_OR:  e.out = x | y;
            OP_XOR: e.out = x ^ y;
            OP_NOT: e.out = ~x;
            OP_SLL: begin
                w = {32'b0, x} << n;
                e.out = w[31:0];
                c = w[32];
            end
            OP_SRL: begin
                e.out = x >> n;
                c = (n > 0) ? x[n-1] : 1'b0;
            end
            OP_SRA: begin
                t = $signed(x) >>> n;
                e.out = t;
                c = (n > 0) ? x[n-1] : 1'b0;
            end
            OP_ROL: begin
                t = x;
                for (int i = 0; i < n; i++) t = {t[30:0], t[31]};
                e.out = t;
            end
            OP_ROR: begin
                t = x;
                for (int i = 0; i < n; i++) t = {t[0], t[31:1]};
                e.out = t;
            end
            OP_SLT: e.out = (sx < sy) ? 32'd1 : 32'd0;
            OP_MUL: begin
                w = {32'b0, x} * {32'b0, y};
                e.out = w[31:0];
            end
            default: begin
                e.err = 1'b1;
                return e;
            end
        endcase
        e.flags = {e.out[31], e.out == 0, c, v};
        return e;
    endfunction

    // Monitor: pops on every output handshake and checks the held result
    // stays put while the consumer stalls.
    exp_t prev;
    bit   hold = 1'b0;
    always @(negedge clk) begin
        exp_t cur, e;
        cur = {out, flags, err};
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) check("hold", {cur, out_valid}, {prev, 1'b1});
            if (out_valid && out_ready && enable) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got %h expected none", cur);
                end else begin
                    e = q.pop_front();
                    check("result", cur, e);
                end
            end
            hold = out_valid && !(out_ready && enable);
            prev = cur;
        end
    end

    task automatic wait_ready(output bit ok);
        int n = 0;
        ok = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                n_cmp++;
                n_bad++;
                $display("FAIL in_ready_timeout: got 0 expected 1");
                ok = 1'b0;
                break;
            end
            @(posedge clk); #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        bit ok;
        opcode = op;
        a = x;
        b = y;
        in_valid = 1'b1;
        wait_ready(ok);
        if (ok) q.push_back(model(op, x, y));
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic expect_now(input string name, input logic [W-1:0] eo,
                              input logic [3:0] ef, input logic ee);
        check({name, "_out"}, out, eo);
        check({name, "_flags"}, flags, ef);
        check({name, "_err"}, err, ee);
    endtask

    task automatic run_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                           input int stall_at, input int exp_lat,
                           input string name);
        int k;
        bit ok;
        opcode = OP_MUL;
        a = x;
        b = y;
        in_valid = 1'b1;
        wait_ready(ok);
        if (ok) q.push_back(model(OP_MUL, x, y));
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (1) begin
            if (k == stall_at) enable = 1'b0;
            if (k == stall_at + 5) enable = 1'b1;
            @(posedge clk);
            k++;
            #1;
            if (out_valid) break;
            check({name, "_in_ready"}, in_ready, 0);
            if (k > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_timeout: got no out_valid", name);
                break;
            end
        end
        enable = 1'b1;
        check({name, "_latency"}, k, exp_lat);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int  n;
        bit  ok;
        logic [4:0] op;

        #1 rst = 1'b1;
        #1;
        check("rst_out", out, 0);
        check("rst_flags", flags, 0);
        check("rst_err", err, 0);
        check("rst_out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("rst_in_ready", in_ready, 1);

        issue(OP_ADD, 32'hFFFFFFFF, 32'h1);
        expect_now("add_wrap", 32'h0, 4'b0110, 1'b0);
        issue(OP_SUB, 32'h80000000, 32'h1);
        expect_now("sub_ovf", 32'h7FFFFFFF, 4'b0011, 1'b0);
        issue(OP_SRA, 32'h0F0F0F0F, 32'hFFFFFFFF);
        expect_now("sra_31", 32'h0, 4'b0100, 1'b0);
        issue(OP_ROR, 32'h0F0F0F0F, 32'h4);
        expect_now("ror_4", 32'hF0F0F0F0, 4'b1000, 1'b0);

        run_mul(32'h0F0F0F0F, 32'h3, -1, 33, "mul");
        expect_now("mul", 32'h2D2D2D2D, 4'b0000, 1'b0);
        issue(5'b10001, 32'h1234, 32'h5678);
        expect_now("illegal", 32'h0, 4'b0000, 1'b1);

        issue(OP_ADD, 32'd1, 32'd2);
        out_ready = 1'b0;
        opcode = OP_ADD;
        a = 32'd10;
        b = 32'd20;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("b2b_in_ready", in_ready, 0);
            check("b2b_held", out, 32'd3);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("b2b_release", in_ready, 1);
        q.push_back(model(OP_ADD, 32'd10, 32'd20));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_valid", out_valid, 1);
        check("b2b_out", out, 32'd30);

        run_mul(32'h12345678, 32'h09ABCDEF, 10, 38, "mul_stall");

        opcode = OP_MUL;
        a = 32'hDEADBEEF;
        b = 32'h00000077;
        in_valid = 1'b1;
        wait_ready(ok);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_out", out, 0);
        check("abort_flags", flags, 0);
        check("abort_err", err, 0);
        check("abort_valid", out_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("abort_in_ready", in_ready, 1);
        repeat (45) @(posedge clk);
        #1 check("abort_no_result", out_valid, 0);

        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) op = 5'($urandom_range(0, 31));
            else op = ops[$urandom_range(0, 12)];
            issue(op, pick(), pick());
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
